pot_conditioner: RTL

Consumes the per-channel 10-bit potentiometer samples produced by the MCP3008 SPI front end. Filters each channel with a first-order exponential moving average and applies a hysteresis deadband, so the guitar filter's coefficient logic sees stable control values with a one-cycle change strobe. The block sits between the ADC interface and the filter parameter registers, entirely in the CLK50 domain. The `valid` level from the ADC interface is generated on the slow SPI clock, so this block synchronises it.

---
 rtl/pot_conditioner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pot_conditioner.sv
// Potentiometer conditioner: synchronised frame strobe, per-channel EMA and
// deadband. Define POT_HYST_EN to enable the hysteresis deadband and endpoint snap.

module pot_lane #(
    parameter int N    = 10,
    parameter int K    = 3,
    parameter int HYST = 4
) (
    input  logic         CLK50,
    input  logic         reset_n,
    input  logic         en,
    input  logic [N-1:0] x,
    output logic [N-1:0] pot,
    output logic         chg
);
    logic [N+K-1:0] acc;
    logic [N+K-1:0] acc_nxt;
    logic [N-1:0]   f;
    logic           primed;
    logic           upd;
`ifdef POT_HYST_EN
    logic signed [N:0] diff;
    logic [N:0]        d;
`endif

    always_comb begin
        acc_nxt = acc - (acc >> K) + {{K{1'b0}}, x};
        f       = acc_nxt[N+K-1:K];
`ifdef POT_HYST_EN
        diff = $signed({1'b0, f}) - $signed({1'b0, pot});
        d    = diff[N] ? (-diff) : diff;
        // endpoints snap even inside the deadband so full travel is reachable
        upd  = (d >= (N+1)'(HYST)) || (((f == '0) || (f == '1)) && (f != pot));
`else
        upd  = (f != pot);
`endif
    end

    always_ff @(posedge CLK50 or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            primed <= 1'b0;
            pot    <= '0;
            chg    <= 1'b0;
        end else begin
            chg <= 1'b0;
            if (en) begin
                if (!primed) begin
                    acc    <= {x, {K{1'b0}}};
                    pot    <= x;
                    primed <= 1'b1;
                    chg    <= 1'b1;
                end else begin
                    acc <= acc_nxt;
                    if (upd) begin
                        pot <= f;
                        chg <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

module pot_conditioner #(
    parameter int CHANNELS = 2,
    parameter int N        = 10,
    parameter int K        = 3,
    parameter int HYST     = 4
) (
    input  logic                         CLK50,
    input  logic                         reset_n,
    input  logic [CHANNELS-1:0][N-1:0]   adc_in,
    input  logic                         valid,
    output logic [CHANNELS-1:0][N-1:0]   pot_out,
    output logic [CHANNELS-1:0]          changed,
    output logic                         busy,
    output logic                         overrun
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t                       state, state_nxt;
    logic [CW-1:0]                c, c_nxt;
    logic [CHANNELS-1:0][N-1:0]   snap;
    logic                         snap_ld;
    logic                         ch_en;
    logic [2:0]                   vld_pipe;
    logic                         frame_edge;

    // s1/s2 synchronise the slow-domain level, s3 detects its rising edge
    assign frame_edge = vld_pipe[1] & ~vld_pipe[2];
    assign busy       = (state == UPDATE);

    always_ff @(posedge CLK50 or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            state    <= IDLE;
            c        <= '0;
            snap     <= '0;
            overrun  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], valid};
            state    <= state_nxt;
            c        <= c_nxt;
            overrun  <= frame_edge & (state == UPDATE);
            if (snap_ld)
                snap <= adc_in;
        end
    end

    always_comb begin
        state_nxt = state;
        c_nxt     = c;
        snap_ld   = 1'b0;
        ch_en     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_edge) begin
                    snap_ld   = 1'b1;
                    c_nxt     = '0;
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                ch_en = 1'b1;
                c_nxt = c + CW'(1);
                if (c == CW'(CHANNELS-1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pot_lane #(.N(N), .K(K), .HYST(HYST)) u_lane (
            .CLK50   (CLK50),
            .reset_n (reset_n),
            .en      (ch_en && (c == CW'(i))),
            .x       (snap[i]),
            .pot     (pot_out[i]),
            .chg     (changed[i])
        );
    end
endmodule
